lzd_iter: RTL and testbench

- Sequential companion to the leading-zero/priority detector.
- Accepts a W-bit vector over a valid/ready handshake, then emits every detected bit position as a stream of one-hot/index beats. Beats leave in priority order, one per handshake.
- Sits between producers of request/occupancy masks (free-lists, pending-bit vectors) and consumers that service one bit per cycle.
- Shares the FROM_LSB/DETECT_ZERO semantics of the priority detector and instantiates pri internally for the per-beat select.

---
 rtl/lzd_iter.sv | 110 +++++++++++
 tb/tb_lzd_iter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lzd_iter.sv
// Iterative priority enumerator: accepts a W-bit mask and streams every detected
// bit position as one-hot/index beats in priority order, one per handshake.

module pri #(
  parameter int unsigned W        = 16,
  parameter int unsigned FROM_LSB = 0
) (
  input  logic [W-1:0] vec,
  output logic [W-1:0] onehot
);

  generate
    if (FROM_LSB != 0) begin : g_lsb
      // Two's-complement trick isolates the lowest set bit.
      assign onehot = vec & (~vec + W'(1));
    end else begin : g_msb
      logic [W-1:0] rev;
      logic [W-1:0] rev_pick;
      for (genvar g = 0; g < int'(W); g++) begin : g_rev
        assign rev[g]                 = vec[W-1-g];
        assign onehot[W-1-g]          = rev_pick[g];
      end
      assign rev_pick = rev & (~rev + W'(1));
    end
  endgenerate

endmodule

module lzd_iter #(
  parameter int unsigned W           = 16,
  parameter int unsigned FROM_LSB    = 0,
  parameter int unsigned DETECT_ZERO = 0,
  parameter int unsigned IW          = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vec_vld,
  input  logic [W-1:0]  i_vec,
  output logic          o_vec_rdy,
  output logic          o_bit_vld,
  output logic [W-1:0]  o_bit_onehot,
  output logic [IW-1:0] o_bit_idx,
  output logic          o_bit_last,
  input  logic          i_bit_rdy,
  output logic          o_busy
);

  localparam logic [W-1:0] XMASK = (DETECT_ZERO != 0) ? {W{1'b1}} : {W{1'b0}};

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   remaining;
  logic [W-1:0]   pick;
  logic [W-1:0]   masked;
  logic           last_c;
  logic           accept;
  logic           xfer;

  pri #(.W(W), .FROM_LSB(FROM_LSB)) u_pri (
    .vec    (remaining),
    .onehot (pick)
  );

  assign masked = i_vec ^ XMASK;
  assign last_c = ((remaining & ~pick) == '0);
  assign accept = i_vec_vld & o_vec_rdy;
  assign xfer   = o_bit_vld & i_bit_rdy;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: an all-zero (after masking) vector is swallowed without a beat.
  always_comb begin
    state_nxt = state;
    if (accept)             state_nxt = (masked != '0) ? SCAN : IDLE;
    else if (xfer && last_c) state_nxt = IDLE;
  end

  // Outputs: beat data is forced to zero outside SCAN.
  always_comb begin
    o_bit_vld    = 1'b0;
    o_bit_onehot = '0;
    o_bit_idx    = '0;
    o_bit_last   = 1'b0;
    o_busy       = 1'b0;
    if (state == SCAN) begin
      o_bit_vld    = 1'b1;
      o_bit_onehot = pick;
      o_bit_last   = last_c;
      o_busy       = 1'b1;
      for (int i = 0; i < int'(W); i++) begin
        if (pick[i]) o_bit_idx = o_bit_idx | IW'(i);
      end
    end
    o_vec_rdy = (state == IDLE) | ((state == SCAN) & i_bit_rdy & last_c);
  end

  // Remaining-bit mask; a final-beat accept reloads it in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)         remaining <= '0;
    else if (accept) remaining <= masked;
    else if (xfer)   remaining <= remaining & ~pick;
  end

endmodule

// File: tb/tb_lzd_iter.sv
// Directed bench for lzd_iter: four instances cover MSB-first, LSB-first,
// zero-detect and a non-power-of-two width.

module tb_lzd_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // dut0: W=8 MSB-first
  logic       vld0, rdy0, vrdy0, bvld0, last0, busy0;
  logic [7:0] vec0, oh0;
  logic [2:0] idx0;
  // dut1: W=8 LSB-first
  logic       vld1, rdy1, vrdy1, bvld1, last1, busy1;
  logic [7:0] vec1, oh1;
  logic [2:0] idx1;
  // dut2: W=8 zero-detect
  logic       vld2, rdy2, vrdy2, bvld2, last2, busy2;
  logic [7:0] vec2, oh2;
  logic [2:0] idx2;
  // dut3: W=5 MSB-first
  logic       vld3, rdy3, vrdy3, bvld3, last3, busy3;
  logic [4:0] vec3, oh3;
  logic [2:0] idx3;

  lzd_iter #(.W(8), .FROM_LSB(0), .DETECT_ZERO(0)) dut0 (
    .clk(clk), .rst(rst), .i_vec_vld(vld0), .i_vec(vec0), .o_vec_rdy(vrdy0),
    .o_bit_vld(bvld0), .o_bit_onehot(oh0), .o_bit_idx(idx0), .o_bit_last(last0),
    .i_bit_rdy(rdy0), .o_busy(busy0));
  lzd_iter #(.W(8), .FROM_LSB(1), .DETECT_ZERO(0)) dut1 (
    .clk(clk), .rst(rst), .i_vec_vld(vld1), .i_vec(vec1), .o_vec_rdy(vrdy1),
    .o_bit_vld(bvld1), .o_bit_onehot(oh1), .o_bit_idx(idx1), .o_bit_last(last1),
    .i_bit_rdy(rdy1), .o_busy(busy1));
  lzd_iter #(.W(8), .FROM_LSB(0), .DETECT_ZERO(1)) dut2 (
    .clk(clk), .rst(rst), .i_vec_vld(vld2), .i_vec(vec2), .o_vec_rdy(vrdy2),
    .o_bit_vld(bvld2), .o_bit_onehot(oh2), .o_bit_idx(idx2), .o_bit_last(last2),
    .i_bit_rdy(rdy2), .o_busy(busy2));
  lzd_iter #(.W(5), .FROM_LSB(0), .DETECT_ZERO(0)) dut3 (
    .clk(clk), .rst(rst), .i_vec_vld(vld3), .i_vec(vec3), .o_vec_rdy(vrdy3),
    .o_bit_vld(bvld3), .o_bit_onehot(oh3), .o_bit_idx(idx3), .o_bit_last(last3),
    .i_bit_rdy(rdy3), .o_busy(busy3));

  // Observation order: {vec_rdy, bit_vld, last, busy, idx, onehot}
  wire [14:0] obs0 = {vrdy0, bvld0, last0, busy0, idx0, oh0};
  wire [14:0] obs1 = {vrdy1, bvld1, last1, busy1, idx1, oh1};
  wire [14:0] obs2 = {vrdy2, bvld2, last2, busy2, idx2, oh2};
  wire [11:0] obs3 = {vrdy3, bvld3, last3, busy3, idx3, oh3};

  localparam logic [14:0] IDLE8 = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
  localparam logic [11:0] IDLE5 = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'h00};

  assert property (@(posedge clk) bvld0 |-> $onehot(oh0));
  assert property (@(posedge clk) bvld1 |-> $onehot(oh1));

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (obs0 !== IDLE8) begin n_fail++; $display("FAIL reset dut0: got %h expected %h", obs0, IDLE8); end
    n_checks++;
    if (obs1 !== IDLE8) begin n_fail++; $display("FAIL reset dut1: got %h expected %h", obs1, IDLE8); end
    n_checks++;
    if (obs2 !== IDLE8) begin n_fail++; $display("FAIL reset dut2: got %h expected %h", obs2, IDLE8); end
    n_checks++;
    if (obs3 !== IDLE5) begin n_fail++; $display("FAIL reset dut3: got %h expected %h", obs3, IDLE5); end
    @(posedge clk); #1;
  endtask

  task automatic test_msb_order();
    logic [14:0] exp [5];
    exp = '{IDLE8,
            {1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 8'h80},
            {1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 8'h20},
            {1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 8'h04},
            IDLE8};
    for (int c = 0; c < 5; c++) begin
      vld0 = (c == 0); vec0 = 8'hA4; rdy0 = 1'b1;
      #1;
      n_checks++;
      if (obs0 !== exp[c]) begin n_fail++; $display("FAIL msb_order cycle %0d: got %h expected %h", c, obs0, exp[c]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lsb_stall();
    logic [14:0] exp [8];
    logic        rdy [8];
    exp = '{IDLE8,
            {1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 8'h04},
            {1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 8'h20},
            {1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 8'h20},
            {1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 8'h20},
            {1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 8'h20},
            {1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80},
            IDLE8};
    rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 8; c++) begin
      vld1 = (c == 0); vec1 = 8'hA4; rdy1 = rdy[c];
      #1;
      n_checks++;
      if (obs1 !== exp[c]) begin n_fail++; $display("FAIL lsb_stall cycle %0d: got %h expected %h", c, obs1, exp[c]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_vector();
    logic [14:0] exp [5];
    logic        vld [5];
    logic [7:0]  vec [5];
    exp = '{IDLE8, IDLE8, IDLE8, {1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01}, IDLE8};
    vld = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vec = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01};
    for (int c = 0; c < 5; c++) begin
      vld0 = vld[c]; vec0 = vec[c]; rdy0 = 1'b1;
      #1;
      n_checks++;
      if (obs0 !== exp[c]) begin n_fail++; $display("FAIL zero_vector cycle %0d: got %h expected %h", c, obs0, exp[c]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_detect_zero();
    logic [14:0] exp [3];
    exp = '{IDLE8, {1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01}, IDLE8};
    for (int c = 0; c < 3; c++) begin
      vld2 = (c == 0); vec2 = 8'hFE; rdy2 = 1'b1;
      #1;
      n_checks++;
      if (obs2 !== exp[c]) begin n_fail++; $display("FAIL detect_zero cycle %0d: got %h expected %h", c, obs2, exp[c]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] exp [5];
    logic        vld [5];
    logic [7:0]  vec [5];
    exp = '{IDLE8,
            {1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 8'h80},
            {1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01},
            {1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 8'h10},
            IDLE8};
    vld = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vec = '{8'h81, 8'h10, 8'h10, 8'h10, 8'h10};
    for (int c = 0; c < 5; c++) begin
      vld0 = vld[c]; vec0 = vec[c]; rdy0 = 1'b1;
      #1;
      n_checks++;
      if (obs0 !== exp[c]) begin n_fail++; $display("FAIL back_to_back cycle %0d: got %h expected %h", c, obs0, exp[c]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [14:0] exp [9];
    logic        vld [9];
    logic [7:0]  vec [9];
    exp = '{IDLE8,
            {1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 8'h80},
            {1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 8'h40},
            {1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 8'h20},
            {1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 8'h10},
            IDLE8,
            IDLE8,
            {1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 8'h02},
            IDLE8};
    vld = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vec = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h02, 8'h02};
    for (int c = 0; c < 9; c++) begin
      vld0 = vld[c]; vec0 = vec[c]; rdy0 = 1'b1;
      rst  = (c == 4);
      #1;
      n_checks++;
      if (obs0 !== exp[c]) begin n_fail++; $display("FAIL reset_mid_scan cycle %0d: got %h expected %h", c, obs0, exp[c]); end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_odd_width();
    logic [11:0] exp [7];
    exp = '{IDLE5,
            {1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 5'b10000},
            {1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 5'b01000},
            {1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 5'b00100},
            {1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 5'b00010},
            {1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 5'b00001},
            IDLE5};
    for (int c = 0; c < 7; c++) begin
      vld3 = (c == 0); vec3 = 5'h1F; rdy3 = 1'b1;
      #1;
      n_checks++;
      if (obs3 !== exp[c]) begin n_fail++; $display("FAIL odd_width cycle %0d: got %h expected %h", c, obs3, exp[c]); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    vld0 = 1'b0; vec0 = '0; rdy0 = 1'b1;
    vld1 = 1'b0; vec1 = '0; rdy1 = 1'b1;
    vld2 = 1'b0; vec2 = '0; rdy2 = 1'b1;
    vld3 = 1'b0; vec3 = '0; rdy3 = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_msb_order();
    test_lsb_stall();
    test_zero_vector();
    test_detect_zero();
    test_back_to_back();
    test_reset_mid_scan();
    test_odd_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
